// File: rtl/alu_sequencer_pkg.sv
// Shared ALU operation codes, instruction field codes and decode helpers
// for the ALU sequencer slice.
package alu_sequencer_pkg;

    localparam int ALU_CODE_W = 4;

    localparam logic [3:0] ALUADD  = 4'd0;
    localparam logic [3:0] ALUSUB  = 4'd1;
    localparam logic [3:0] ALUSLL  = 4'd2;
    localparam logic [3:0] ALUSLT  = 4'd3;
    localparam logic [3:0] ALUSLTU = 4'd4;
    localparam logic [3:0] ALUXOR  = 4'd5;
    localparam logic [3:0] ALUSRL  = 4'd6;
    localparam logic [3:0] ALUSRA  = 4'd7;
    localparam logic [3:0] ALUOR   = 4'd8;
    localparam logic [3:0] ALUAND  = 4'd9;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALUSLL) || (op == ALUSRL) || (op == ALUSRA);
    endfunction

endpackage

// File: rtl/alu_sequencer_controller.sv
// Combinational opcode/func3/func7 decode into an ALU operation code.
module alu_controller
    import alu_sequencer_pkg::*;
#(
    parameter int IWIDTH = 11,
    parameter int AWIDTH = 4
) (
    input  logic [IWIDTH-1:0] instr,
    output logic [AWIDTH-1:0] aluop
);

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7b;
    logic [3:0] code;

    assign opcode = instr[6:0];
    assign func3  = instr[9:7];
    assign func7b = instr[10];

    // func7[5] only selects SUB for register-register adds; ADDI has no subtract form
    always_comb begin
        code = ALUADD;
        case (opcode)
            OP_RTYPE, OP_ITYPE: begin
                case (func3)
                    F3_ADD:  code = (opcode == OP_RTYPE && func7b) ? ALUSUB : ALUADD;
                    F3_SLL:  code = ALUSLL;
                    F3_SLT:  code = ALUSLT;
                    F3_SLTU: code = ALUSLTU;
                    F3_XOR:  code = ALUXOR;
                    F3_SR:   code = func7b ? ALUSRA : ALUSRL;
                    F3_OR:   code = ALUOR;
                    F3_AND:  code = ALUAND;
                    default: code = ALUADD;
                endcase
            end
            OP_LOAD, OP_STORE: code = ALUADD;
            default:           code = ALUADD;
        endcase
        aluop = AWIDTH'(code);
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/result sequencer around an external combinational ALU.
// Define SERIAL_SHIFT_EN to perform shifts as k single-bit ALU iterations.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IWIDTH = 11,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IWIDTH-1:0] in_instr,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic [4:0]        in_rd,
    output logic [AWIDTH-1:0] alu_op,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    input  logic [XLEN-1:0]   alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [4:0]        out_rd,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    state_t            state;
    logic [AWIDTH-1:0] dec_op;
    logic [AWIDTH-1:0] op_r;
    logic [XLEN-1:0]   a_r;
    logic [XLEN-1:0]   b_r;
    logic [4:0]        rd_r;
    logic [4:0]        shamt;
    logic              dec_shift;
`ifdef SERIAL_SHIFT_EN
    logic [4:0]        cnt;
`endif

    alu_controller #(
        .IWIDTH (IWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ctrl (
        .instr (in_instr),
        .aluop (dec_op)
    );

    assign shamt     = in_b[4:0];
    assign dec_shift = is_shift_op(4'(dec_op));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_result <= '0;
            out_rd     <= '0;
`ifdef SERIAL_SHIFT_EN
            cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r <= dec_op;
                        a_r  <= in_a;
                        // shifts only honour the low five bits of operand B
                        b_r  <= dec_shift ? XLEN'(shamt) : in_b;
                        rd_r <= in_rd;
`ifdef SERIAL_SHIFT_EN
                        if (dec_shift && shamt != 5'd0) begin
                            cnt   <= shamt;
                            state <= SHIFT;
                        end else begin
                            state <= EXEC;
                        end
`else
                        state <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    out_result <= alu_result;
                    out_rd     <= rd_r;
                    state      <= DONE;
                end
`ifdef SERIAL_SHIFT_EN
                SHIFT: begin
                    a_r <= alu_result;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        out_result <= alu_result;
                        out_rd     <= rd_r;
                        state      <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // the ALU sees ADD 0,0 whenever no operation is in flight
    always_comb begin
        alu_op = AWIDTH'(ALUADD);
        alu_a  = '0;
        alu_b  = '0;
        case (state)
            EXEC: begin
                alu_op = op_r;
                alu_a  = a_r;
                alu_b  = b_r;
            end
`ifdef SERIAL_SHIFT_EN
            SHIFT: begin
                alu_op = op_r;
                alu_a  = a_r;
                alu_b  = XLEN'(1);
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural external ALU.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_instr;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_rd;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;

    int vecs = 0;
    int errs = 0;

`ifdef SERIAL_SHIFT_EN
    localparam int LAT_K4  = 5;
    localparam int LAT_K31 = 32;
`else
    localparam int LAT_K4  = 2;
    localparam int LAT_K31 = 2;
`endif

    localparam logic [10:0] I_ADD   = {1'b0, 3'b000, 7'b0110011};
    localparam logic [10:0] I_SUB   = {1'b1, 3'b000, 7'b0110011};
    localparam logic [10:0] I_SLL   = {1'b0, 3'b001, 7'b0110011};
    localparam logic [10:0] I_SRA   = {1'b1, 3'b101, 7'b0110011};
    localparam logic [10:0] I_SLTU  = {1'b0, 3'b011, 7'b0110011};
    localparam logic [10:0] I_ANDI  = {1'b0, 3'b111, 7'b0010011};
    localparam logic [10:0] I_SLTI  = {1'b0, 3'b010, 7'b0010011};
    localparam logic [10:0] I_SRLI  = {1'b0, 3'b101, 7'b0010011};
    localparam logic [10:0] I_LW    = {1'b0, 3'b010, 7'b0000011};
    localparam logic [10:0] I_SW    = {1'b0, 3'b010, 7'b0100011};
    localparam logic [10:0] I_BAD   = {1'b1, 3'b000, 7'b1111111};

    alu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_rd      (in_rd),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALUADD:  alu_result = alu_a + alu_b;
            ALUSUB:  alu_result = alu_a - alu_b;
            ALUSLL:  alu_result = alu_a << alu_b[4:0];
            ALUSLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALUSLTU: alu_result = {31'd0, alu_a < alu_b};
            ALUXOR:  alu_result = alu_a ^ alu_b;
            ALUSRL:  alu_result = alu_a >> alu_b[4:0];
            ALUSRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            ALUOR:   alu_result = alu_a | alu_b;
            ALUAND:  alu_result = alu_a & alu_b;
            default: alu_result = '0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [10:0] instr, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        in_valid = 1'b1;
        in_instr = instr;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        step();
        in_valid = 1'b0;
    endtask

    // lat counts cycles after the issue edge; -1 means out_valid never came
    task automatic wait_valid(input int limit, output int lat);
        lat = 1;
        while (!out_valid && lat < limit) begin
            step();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vecs++; if (out_result !== 32'd0) begin errs++; $display("FAIL reset_out_result got %h want 0", out_result); end
        vecs++; if (out_rd !== 5'd0) begin errs++; $display("FAIL reset_out_rd got %0d want 0", out_rd); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vecs++; if ({alu_op, alu_a, alu_b} !== 68'd0) begin errs++; $display("FAIL reset_alu_idle got %h/%h/%h want 0", alu_op, alu_a, alu_b); end
    endtask

    task automatic test_add();
        int lat;
        issue(I_ADD, 32'd5, 32'd7, 5'd3);
        vecs++; if (alu_op !== ALUADD || alu_a !== 32'd5 || alu_b !== 32'd7) begin errs++; $display("FAIL add_exec_drive got %h/%h/%h want 0/5/7", alu_op, alu_a, alu_b); end
        vecs++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errs++; $display("FAIL add_busy got busy=%b ready=%b want 1/0", busy, in_ready); end
        wait_valid(8, lat);
        vecs++; if (lat !== 2) begin errs++; $display("FAIL add_latency got %0d want 2", lat); end
        vecs++; if (out_result !== 32'd12 || out_rd !== 5'd3) begin errs++; $display("FAIL add_result got %h rd %0d want c rd 3", out_result, out_rd); end
        step();
        vecs++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL add_return got ready=%b valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_decode();
        logic [10:0] ins [7]  = '{I_SUB, I_ANDI, I_SLTI, I_SLTU, I_LW, I_SW, I_BAD};
        logic [31:0] av [7]   = '{32'd3, 32'h0000F0F0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'h1000, 32'd9};
        logic [31:0] bv [7]   = '{32'd5, 32'h00000FF0, 32'd1, 32'd1, 32'hFFFFFFFC, 32'd8, 32'd4};
        logic [31:0] ev [7]   = '{32'hFFFFFFFE, 32'h000000F0, 32'd1, 32'd0, 32'd96, 32'h1008, 32'd13};
        for (int i = 0; i < 7; i++) begin
            int lat;
            issue(ins[i], av[i], bv[i], 5'(i + 10));
            wait_valid(8, lat);
            vecs++; if (lat !== 2 || out_result !== ev[i] || out_rd !== 5'(i + 10)) begin
                errs++; $display("FAIL decode_%0d got lat %0d res %h rd %0d want 2 %h %0d", i, lat, out_result, out_rd, ev[i], i + 10);
            end
            step();
        end
    endtask

    task automatic test_shift();
        int lat;
        issue(I_SLL, 32'd1, 32'd4, 5'd7);
`ifdef SERIAL_SHIFT_EN
        for (int i = 0; i < 4; i++) begin
            vecs++; if (alu_b !== 32'd1 || alu_a !== (32'd1 << i) || alu_op !== ALUSLL) begin
                errs++; $display("FAIL sll_iter_%0d got a=%h b=%h op=%0d want a=%h b=1 op=2", i, alu_a, alu_b, alu_op, 32'd1 << i);
            end
            if (i < 3) step();
        end
        lat = 4;
        while (!out_valid && lat < 40) begin step(); lat++; end
        if (!out_valid) lat = -1;
`else
        vecs++; if (alu_b !== 32'd4 || alu_op !== ALUSLL) begin errs++; $display("FAIL sll_exec got b=%h op=%0d want 4/2", alu_b, alu_op); end
        wait_valid(40, lat);
`endif
        vecs++; if (lat !== LAT_K4 || out_result !== 32'd16 || out_rd !== 5'd7) begin
            errs++; $display("FAIL sll_result got lat %0d res %h rd %0d want %0d 10 7", lat, out_result, out_rd, LAT_K4);
        end
        step();
        issue(I_SRA, 32'h80000000, 32'd31, 5'd8);
        wait_valid(40, lat);
        vecs++; if (lat !== LAT_K31 || out_result !== 32'hFFFFFFFF) begin
            errs++; $display("FAIL sra_result got lat %0d res %h want %0d ffffffff", lat, out_result, LAT_K31);
        end
        step();
        issue(I_SRLI, 32'h80000000, 32'hFFFFFFE4, 5'd9);
        wait_valid(40, lat);
        vecs++; if (lat !== LAT_K4 || out_result !== 32'h08000000) begin
            errs++; $display("FAIL srli_upper_ignored got lat %0d res %h want %0d 08000000", lat, out_result, LAT_K4);
        end
        step();
    endtask

    task automatic test_shift_zero();
        int lat;
        issue(I_SLL, 32'h00001234, 32'h00000020, 5'd4);
        vecs++; if (alu_b !== 32'd0 || alu_a !== 32'h1234) begin errs++; $display("FAIL shift0_exec got a=%h b=%h want 1234/0", alu_a, alu_b); end
        wait_valid(8, lat);
        vecs++; if (lat !== 2 || out_result !== 32'h00001234) begin errs++; $display("FAIL shift0_result got lat %0d res %h want 2 1234", lat, out_result); end
        step();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        out_ready = 1'b0;
        issue(I_ADD, 32'd20, 32'd22, 5'd17);
        wait_valid(8, lat);
        vecs++; if (lat !== 2) begin errs++; $display("FAIL bp_latency got %0d want 2", lat); end
        vecs++; if ({alu_op, alu_a, alu_b} !== 68'd0) begin errs++; $display("FAIL bp_done_alu got %h/%h/%h want 0", alu_op, alu_a, alu_b); end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_instr = I_SUB;
            in_a     = 32'd1;
            in_b     = 32'd2;
            in_rd    = 5'd30;
            step();
            if (out_valid !== 1'b1 || out_result !== 32'd42 || out_rd !== 5'd17 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        vecs++; if (bad !== 0) begin errs++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        out_ready = 1'b1;
        step();
        vecs++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", in_ready, out_valid); end
        step();
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL bp_no_ghost_issue got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        out_ready = 1'b0;
        issue(I_SLL, 32'd1, 32'd20, 5'd21);
        for (int i = 0; i < 4; i++) step();
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL midrst_busy got %b want 1", busy); end
        rst_n = 1'b0;
        step();
        vecs++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'd0) begin
            errs++; $display("FAIL midrst_idle got busy=%b valid=%b res=%h want 0/0/0", busy, out_valid, out_result);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL midrst_ready got %b want 1", in_ready); end
        for (int i = 0; i < 25; i++) begin
            if (out_valid) pulses++;
            step();
        end
        vecs++; if (pulses !== 0) begin errs++; $display("FAIL midrst_no_valid got %0d pulses want 0", pulses); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_a      = '0;
        in_b      = '0;
        in_rd     = '0;
        out_ready = 1'b1;
        #1;
        test_reset();
        test_add();
        test_decode();
        test_shift();
        test_shift_zero();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
